// File: rtl/disp_scanner.sv
// rtl/disp_scanner.sv - multiplexed hex display scanner with double-buffered value
module disp_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   SEG,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  output logic [3:0]            DISP,
  output logic [DIGITS-1:0]     DIGIT_SEL,
  output logic [6:0]            SEG7,
  output logic                  FRAME,
  output logic                  PEND
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(PRESCALE - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [PCW-1:0]      pc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_reg;
  logic [4*DIGITS-1:0] disp_reg;
  logic                pend_q;
  logic                frame_q;

  logic                tick;
  logic                boundary;
  logic [3:0]          nib;
  logic                upper_zero;
  logic                blanked;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick     = (pc == PC_LAST);
  assign boundary = tick && (idx == IDX_LAST);
  assign PEND     = pend_q;
  assign FRAME    = frame_q;

  // Scan counters plus double buffer; a boundary swaps in the pending value so frames never tear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= '0;
      idx      <= '0;
      pend_reg <= '0;
      disp_reg <= '0;
      pend_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      frame_q <= boundary;
      if (tick) begin
        pc  <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        pc <= pc + PCW'(1);
      end
      if (LOAD && boundary) begin
        pend_reg <= SEG;
        disp_reg <= SEG;
        pend_q   <= 1'b0;
      end else if (LOAD) begin
        pend_reg <= SEG;
        pend_q   <= 1'b1;
      end else if (boundary && pend_q) begin
        disp_reg <= pend_reg;
        pend_q   <= 1'b0;
      end
    end
  end

  // Select the active nibble and find whether it and every more-significant nibble are zero.
  always_comb begin
    nib        = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) nib = disp_reg[4*i +: 4];
      if ((i >= int'(idx)) && (disp_reg[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  // Drive the pins; a blanked digit turns everything off, digit 0 always shows.
  always_comb begin
    blanked   = BLANK_LZ && (idx != '0) && upper_zero;
    DIGIT_SEL = '0;
    DISP      = 4'd0;
    SEG7      = 7'd0;
    if (!blanked) begin
      DIGIT_SEL = DIGITS'(1) << idx;
      DISP      = nib;
      SEG7      = hex7(nib);
    end
  end

endmodule

// File: tb/tb_disp_scanner.sv
// tb/tb_disp_scanner.sv - self-checking bench for disp_scanner
module tb_disp_scanner;

  localparam int D = 4;
  localparam int P = 2;
  localparam int F = D * P;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [4*D-1:0] SEG = '0;
  logic           LOAD = 1'b0;
  logic           BLANK_LZ = 1'b0;
  logic [3:0]     DISP;
  logic [D-1:0]   DIGIT_SEL;
  logic [6:0]     SEG7;
  logic           FRAME;
  logic           PEND;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int             t = 0;
  bit             mvalid = 0;
  logic [4*D-1:0] mdisp = '0;
  logic [4*D-1:0] mpval = '0;
  bit             mpend = 0;
  bit             mframe = 0;
  logic [6:0]     seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  disp_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .SEG(SEG), .LOAD(LOAD), .BLANK_LZ(BLANK_LZ),
    .DISP(DISP), .DIGIT_SEL(DIGIT_SEL), .SEG7(SEG7), .FRAME(FRAME), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic compare_model();
    int i;
    logic [15:0] upper;
    logic [3:0] nib;
    bit blank;
    i     = (t / P) % D;
    upper = mdisp >> (4 * i);
    nib   = upper[3:0];
    blank = BLANK_LZ && (i != 0) && (upper == 16'd0);
    chk("model_digit_sel", 32'(DIGIT_SEL), blank ? 32'd0 : 32'(1 << i));
    chk("model_disp", 32'(DISP), blank ? 32'd0 : 32'(nib));
    chk("model_seg7", 32'(SEG7), blank ? 32'd0 : 32'(seg_tbl[nib]));
    chk("model_frame", 32'(FRAME), 32'(mframe));
    chk("model_pend", 32'(PEND), 32'(mpend));
  endtask

  // One clock: compare at the falling edge, advance the model with the current inputs, leave 1 unit after the rise.
  task automatic step();
    bit bnd;
    @(negedge CLK);
    if (mvalid) compare_model();
    if (RST) begin
      t = 0; mdisp = '0; mpval = '0; mpend = 0; mframe = 0; mvalid = 1;
    end else begin
      bnd = ((t % F) == F - 1);
      mframe = bnd;
      if (LOAD && bnd) begin
        mdisp = SEG; mpval = SEG; mpend = 0;
      end else if (LOAD) begin
        mpval = SEG; mpend = 1;
      end else if (bnd && mpend) begin
        mdisp = mpval; mpend = 0;
      end
      t++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int frames;
    bit saw_1111;

    // reset, digit 0 shows 0 even with blanking enabled
    RST = 1'b1; BLANK_LZ = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_digit_sel", 32'(DIGIT_SEL), 32'h1);
    chk("rst_seg7", 32'(SEG7), 32'h3F);
    chk("rst_disp", 32'(DISP), 32'h0);
    chk("rst_pend", 32'(PEND), 32'h0);
    BLANK_LZ = 1'b0;

    // free scan, two frames
    frames = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (FRAME) frames++;
    end
    chk("frame_count_16cyc", 32'(frames), 32'd2);

    // single load at idx 1 (t=18)
    steps(2);
    LOAD = 1'b1; SEG = 16'h1A2F;
    step();
    LOAD = 1'b0;
    chk("load_pend_set", 32'(PEND), 32'h1);
    chk("load_not_shown_yet", 32'(DISP), 32'h0);
    steps(5);
    chk("1a2f_d0_seg7", 32'(SEG7), 32'h71);
    chk("1a2f_pend_clear", 32'(PEND), 32'h0);
    steps(2);
    chk("1a2f_d1_seg7", 32'(SEG7), 32'h5B);
    steps(2);
    chk("1a2f_d2_seg7", 32'(SEG7), 32'h77);
    steps(2);
    chk("1a2f_d3_seg7", 32'(SEG7), 32'h06);

    // leading-zero blanking of 0005 (load at t=30)
    LOAD = 1'b1; SEG = 16'h0005;
    step();
    LOAD = 1'b0; BLANK_LZ = 1'b1;
    step();
    chk("0005_d0_seg7", 32'(SEG7), 32'h6D);
    steps(2);
    chk("0005_d1_sel_blank", 32'(DIGIT_SEL), 32'h0);
    chk("0005_d1_seg7_blank", 32'(SEG7), 32'h0);
    steps(6);
    BLANK_LZ = 1'b0;
    steps(2);
    chk("0005_d1_noblank_seg7", 32'(SEG7), 32'h3F);

    // 0305: inner zero stays visible (load at t=42)
    BLANK_LZ = 1'b1;
    LOAD = 1'b1; SEG = 16'h0305;
    step();
    LOAD = 1'b0;
    steps(5);
    steps(2);
    chk("0305_d1_sel", 32'(DIGIT_SEL), 32'h2);
    chk("0305_d1_seg7", 32'(SEG7), 32'h3F);
    steps(4);
    chk("0305_d3_sel_blank", 32'(DIGIT_SEL), 32'h0);
    BLANK_LZ = 1'b0;

    // back-to-back loads: last wins
    steps(2);
    LOAD = 1'b1; SEG = 16'h1111;
    step();
    LOAD = 1'b0;
    step();
    LOAD = 1'b1; SEG = 16'h2222;
    step();
    LOAD = 1'b0;
    saw_1111 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (DISP == 4'h1) saw_1111 = 1;
    end
    chk("1111_never_shown", 32'(saw_1111), 32'h0);
    chk("2222_d0_disp", 32'(DISP), 32'h2);
    chk("2222_d0_seg7", 32'(SEG7), 32'h5B);

    // load exactly on the boundary cycle (t=71)
    steps(7);
    LOAD = 1'b1; SEG = 16'h4321;
    step();
    LOAD = 1'b0;
    chk("bnd_load_disp", 32'(DISP), 32'h1);
    chk("bnd_load_pend", 32'(PEND), 32'h0);

    // reset mid-frame with a pending value and a simultaneous load
    LOAD = 1'b1; SEG = 16'h5678;
    step();
    chk("pre_rst_pend", 32'(PEND), 32'h1);
    RST = 1'b1; SEG = 16'h9999;
    step();
    RST = 1'b0; LOAD = 1'b0;
    chk("midrst_digit_sel", 32'(DIGIT_SEL), 32'h1);
    chk("midrst_pend", 32'(PEND), 32'h0);
    chk("midrst_seg7", 32'(SEG7), 32'h3F);
    chk("midrst_disp", 32'(DISP), 32'h0);
    step();
    chk("midrst_full_dwell", 32'(DIGIT_SEL), 32'h1);
    step();
    chk("midrst_next_digit", 32'(DIGIT_SEL), 32'h2);
    steps(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout t=%0d actual=running expected=done", t);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
